// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire spike generator.
package lif_pkg;

    localparam int LIF_WIDTH       = 20;
    localparam int LIF_WT_WIDTH    = 8;
    localparam int LIF_LEAK_PERIOD = 16;
    localparam int LIF_LEAK_SHIFT  = 4;
    localparam int LIF_REFRAC      = 4;

    // Working width for saturating arithmetic; holds any p_width up to 38 bits plus sign.
    localparam int LIF_SAT_W = 40;

    typedef enum logic [1:0] {
        IDLE,
        INTEG,
        FIRE,
        REFRAC
    } lif_state_e;

    // Signed sum clamped to the unsigned range [0, 2^w-1].
    function automatic logic [LIF_SAT_W-1:0] sat_add(
        input logic signed [LIF_SAT_W-1:0] a,
        input logic signed [LIF_SAT_W-1:0] b,
        input int unsigned                 w
    );
        logic signed [LIF_SAT_W-1:0] sum;
        logic signed [LIF_SAT_W-1:0] top;
        sum = a + b;
        top = (LIF_SAT_W'(1) << w) - LIF_SAT_W'(1);
        if (sum[LIF_SAT_W-1]) return '0;
        if (sum > top) return top;
        return sum;
    endfunction

endpackage

// File: rtl/lif_leak_timer.sv
// Leak period counter: advances only while the neuron integrates and strobes leak_tick on wrap.
module lif_leak_timer
    import lif_pkg::*;
#(
    parameter int p_leak_period = LIF_LEAK_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_leak_tick
);

    localparam int CW = $clog2(p_leak_period);

    logic [CW-1:0] cnt;

    assign o_leak_tick = i_run && (cnt == CW'(p_leak_period - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_run) begin
            cnt <= o_leak_tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lif_spike_gen.sv
// Leaky integrate-and-fire neuron: leak, add, compare each INTEG cycle, then FIRE and REFRAC.
// Optional adaptive threshold offset enabled by defining LIF_ADAPT_THRESH_EN.
module lif_spike_gen
    import lif_pkg::*;
#(
    parameter int p_width       = LIF_WIDTH,
    parameter int p_wt_width    = LIF_WT_WIDTH,
    parameter int p_leak_period = LIF_LEAK_PERIOD,
    parameter int p_leak_shift  = LIF_LEAK_SHIFT,
    parameter int p_refrac      = LIF_REFRAC
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_syn_valid,
    input  logic signed [p_wt_width-1:0] i_syn_wt,
    input  logic        [p_width-1:0]    i_threshold,
    output logic                         o_spike,
    output logic        [p_width-1:0]    o_sv,
    output logic                         o_refrac
);

    localparam int RC_W = (p_refrac > 1) ? $clog2(p_refrac) : 1;

    lif_state_e         state, state_d;
    logic [p_width-1:0] v, v_d, sv_d;
    logic [p_width-1:0] v_leak, v_add, eff_th;
    logic [RC_W-1:0]    rcnt, rcnt_d;
    logic               spike_d, refrac_d;
    logic               run_integ, leak_tick, fire;

    assign run_integ = (state == INTEG) && i_en;

    lif_leak_timer #(
        .p_leak_period(p_leak_period)
    ) u_leak_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (run_integ),
        .o_leak_tick(leak_tick)
    );

    // Leak is applied before the synaptic add within the same cycle.
    assign v_leak = leak_tick ? v - (v >> p_leak_shift) : v;
    assign v_add  = i_syn_valid
                  ? p_width'(sat_add($signed(LIF_SAT_W'(v_leak)), LIF_SAT_W'(i_syn_wt), p_width))
                  : v_leak;
    assign fire   = (v_add >= eff_th);

`ifdef LIF_ADAPT_THRESH_EN
    logic [p_width-1:0] offset, offset_d, off_decay;

    assign eff_th    = p_width'(sat_add($signed(LIF_SAT_W'(i_threshold)),
                                        $signed(LIF_SAT_W'(offset)), p_width));
    assign off_decay = leak_tick ? offset - (offset >> p_leak_shift) : offset;

    always_comb begin
        offset_d = offset;
        if (run_integ) begin
            offset_d = fire
                     ? p_width'(sat_add($signed(LIF_SAT_W'(off_decay)),
                                        $signed(LIF_SAT_W'(i_threshold >> 3)), p_width))
                     : off_decay;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) offset <= '0;
        else          offset <= offset_d;
    end
`else
    assign eff_th = i_threshold;
`endif

    always_comb begin
        state_d  = state;
        v_d      = v;
        sv_d     = o_sv;
        spike_d  = 1'b0;
        refrac_d = o_refrac;
        rcnt_d   = rcnt;
        case (state)
            IDLE: begin
                if (i_en) state_d = INTEG;
            end
            INTEG: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (fire) begin
                    sv_d    = v_add;
                    spike_d = 1'b1;
                    v_d     = '0;
                    state_d = FIRE;
                end else begin
                    v_d  = v_add;
                    sv_d = v_add;
                end
            end
            FIRE: begin
                sv_d     = '0;
                rcnt_d   = RC_W'(p_refrac - 1);
                refrac_d = 1'b1;
                state_d  = REFRAC;
            end
            REFRAC: begin
                if (rcnt == '0) begin
                    refrac_d = 1'b0;
                    state_d  = i_en ? INTEG : IDLE;
                end else begin
                    rcnt_d = rcnt - RC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            v        <= '0;
            o_sv     <= '0;
            o_spike  <= 1'b0;
            o_refrac <= 1'b0;
            rcnt     <= '0;
        end else begin
            state    <= state_d;
            v        <= v_d;
            o_sv     <= sv_d;
            o_spike  <= spike_d;
            o_refrac <= refrac_d;
            rcnt     <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_lif_spike_gen.sv
// Bench for lif_spike_gen: vector table and corner sequences on a no-leak instance,
// leak sequence and randomized model comparison on a leaking instance.
module tb_lif_spike_gen;

    localparam int MAXV = (1 << 20) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_en = 1'b0, a_vld = 1'b0;
    logic signed [7:0] a_wt = '0;
    logic [19:0] a_thr = '0;
    logic        a_spike, a_refrac;
    logic [19:0] a_sv;

    logic        b_en = 1'b0, b_vld = 1'b0;
    logic signed [7:0] b_wt = '0;
    logic [19:0] b_thr = '0;
    logic        b_spike, b_refrac;
    logic [19:0] b_sv;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    lif_spike_gen #(.p_leak_period(65536)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .i_syn_valid(a_vld), .i_syn_wt(a_wt),
        .i_threshold(a_thr), .o_spike(a_spike), .o_sv(a_sv), .o_refrac(a_refrac)
    );

    lif_spike_gen #(.p_leak_period(16), .p_leak_shift(4), .p_refrac(4)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_syn_valid(b_vld), .i_syn_wt(b_wt),
        .i_threshold(b_thr), .o_spike(b_spike), .o_sv(b_sv), .o_refrac(b_refrac)
    );

    typedef struct {
        bit rst;
        bit en;
        bit vld;
        int wt;
        int thr;
        bit e_spike;
        int e_sv;
        bit e_refrac;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit en, bit vld, int wt, int thr,
                                bit esp, int esv, bit erf);
        vec_t r;
        r.rst = rst; r.en = en; r.vld = vld; r.wt = wt; r.thr = thr;
        r.e_spike = esp; r.e_sv = esv; r.e_refrac = erf;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic sp, input logic [19:0] sv, input logic rf,
                       input logic esp, input logic [19:0] esv, input logic erf);
        n_total++;
        if (sp === esp && sv === esv && rf === erf) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got spike=%0b sv=%0d refrac=%0b, expected spike=%0b sv=%0d refrac=%0b",
                     nm, idx, sp, sv, rf, esp, esv, erf);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_en = 1'b0; a_vld = 1'b0; a_wt = '0;
        b_en = 1'b0; b_vld = 1'b0; b_wt = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step_a(input bit en, input bit vld, input int wt, input int thr);
        @(negedge clk);
        a_en = en; a_vld = vld; a_wt = 8'(wt); a_thr = 20'(thr);
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input bit en, input bit vld, input int wt, input int thr);
        @(negedge clk);
        b_en = en; b_vld = vld; b_wt = 8'(wt); b_thr = 20'(thr);
        @(posedge clk);
        #1;
    endtask

    // Reference model state for instance B (period 16, shift 4, refractory 4).
    bit     m_act, m_fire, e_sp, e_rf;
    int     m_rleft, m_lcnt;
    longint m_v, m_off, e_sv;

    task automatic model_reset();
        m_act = 0; m_fire = 0; m_rleft = 0; m_lcnt = 0;
        m_v = 0; m_off = 0; e_sp = 0; e_rf = 0; e_sv = 0;
    endtask

    task automatic model_cycle(input bit en, input bit vld, input int wt, input int thr);
        longint eff;
        e_sp = 0;
        if (m_fire) begin
            m_fire = 0; e_sv = 0; e_rf = 1; m_rleft = 4;
        end else if (m_rleft > 0) begin
            m_rleft--;
            if (m_rleft == 0) begin
                e_rf = 0;
                m_act = en;
            end
        end else if (!m_act) begin
            m_act = en;
        end else if (!en) begin
            m_act = 0;
        end else begin
`ifdef LIF_ADAPT_THRESH_EN
            eff = thr + m_off;
            if (eff > MAXV) eff = MAXV;
`else
            eff = thr;
`endif
            m_lcnt++;
            if (m_lcnt == 16) begin
                m_lcnt = 0;
                m_v = m_v - (m_v / 16);
                m_off = m_off - (m_off / 16);
            end
            if (vld) begin
                m_v = m_v + wt;
                if (m_v < 0) m_v = 0;
                if (m_v > MAXV) m_v = MAXV;
            end
            if (m_v >= eff) begin
                e_sp = 1; e_sv = m_v; m_v = 0; m_fire = 1;
                m_off = m_off + (thr / 8);
                if (m_off > MAXV) m_off = MAXV;
            end else begin
                e_sv = m_v;
            end
        end
    endtask

    initial begin
        vec_t v;
        int   thr_r;
        logic [19:0] esv20;

        // Reset state of both instances
        #3;
        chk("reset_a", 0, a_spike, a_sv, a_refrac, 1'b0, 20'd0, 1'b0);
        chk("reset_b", 0, b_spike, b_sv, b_refrac, 1'b0, 20'd0, 1'b0);

        // Integrate to threshold 100, then refractory with events dropped
        vecs.push_back(mk(1, 1, 0,   0, 100, 0,   0, 0));
        vecs.push_back(mk(0, 1, 1,  25, 100, 0,  25, 0));
        vecs.push_back(mk(0, 1, 1,  25, 100, 0,  50, 0));
        vecs.push_back(mk(0, 1, 1,  25, 100, 0,  75, 0));
        vecs.push_back(mk(0, 1, 1,  25, 100, 1, 100, 0));
        vecs.push_back(mk(0, 1, 1,  25, 100, 0,   0, 1));
        vecs.push_back(mk(0, 1, 1, 127, 100, 0,   0, 1));
        vecs.push_back(mk(0, 1, 1, 127, 100, 0,   0, 1));
        vecs.push_back(mk(0, 1, 1, 127, 100, 0,   0, 1));
        vecs.push_back(mk(0, 1, 1, 127, 100, 0,   0, 0));
        vecs.push_back(mk(0, 1, 1, 127, 100, 1, 127, 0));
        vecs.push_back(mk(0, 1, 1, 127, 100, 0,   0, 1));
        // Saturation at zero
        vecs.push_back(mk(1, 1, 0,   0, 1000, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1,  10, 1000, 0, 10, 0));
        vecs.push_back(mk(0, 1, 1, -50, 1000, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1,  -1, 1000, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1,   7, 1000, 0,  7, 0));
        // Threshold zero fires on first INTEG cycle
        vecs.push_back(mk(1, 1, 0,   0,    0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 0,   0,    0, 1,  0, 0));
        // Enable drop retains potential; IDLE ignores events
        vecs.push_back(mk(1, 1, 0,   0, 1000, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1,  40, 1000, 0, 40, 0));
        vecs.push_back(mk(0, 0, 1,  50, 1000, 0, 40, 0));
        vecs.push_back(mk(0, 0, 1,  50, 1000, 0, 40, 0));
        vecs.push_back(mk(0, 1, 1,  50, 1000, 0, 40, 0));
        vecs.push_back(mk(0, 1, 1,  10, 1000, 0, 50, 0));
        // Enable drop during FIRE/REFRAC completes the sequence, then IDLE
        vecs.push_back(mk(1, 1, 0,   0,   20, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1,  30,   20, 1, 30, 0));
        vecs.push_back(mk(0, 0, 0,   0,   20, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0,   0,   20, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0,   0,   20, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0,   0,   20, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0,   0,   20, 0,  0, 0));
        vecs.push_back(mk(0, 0, 1,  30,   20, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1,  30,   20, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1,   5,   20, 0,  5, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset();
            step_a(v.en, v.vld, v.wt, v.thr);
            chk("vec", i, a_spike, a_sv, a_refrac, v.e_spike, 20'(v.e_sv), v.e_refrac);
        end

        // Saturation at the top of the range
        do_reset();
        step_a(1, 0, 0, MAXV);
        for (int i = 0; i < 8256; i++) step_a(1, 1, 127, MAXV);
        step_a(1, 1, 54, MAXV);
        chk("sat_near_top", 0, a_spike, a_sv, a_refrac, 1'b0, 20'd1048566, 1'b0);
        step_a(1, 1, 100, MAXV);
        chk("sat_top", 0, a_spike, a_sv, a_refrac, 1'b1, 20'd1048575, 1'b0);

        // Asynchronous reset while in FIRE
        do_reset();
        step_a(1, 0, 0, 100);
        step_a(1, 1, 100, 100);
        chk("pre_rst_fire", 0, a_spike, a_sv, a_refrac, 1'b1, 20'd100, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_in_fire", 0, a_spike, a_sv, a_refrac, 1'b0, 20'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset while in REFRAC
        step_a(1, 0, 0, 100);
        step_a(1, 1, 100, 100);
        step_a(1, 0, 0, 100);
        chk("pre_rst_refrac", 0, a_spike, a_sv, a_refrac, 1'b0, 20'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_in_refrac", 0, a_spike, a_sv, a_refrac, 1'b0, 20'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef LIF_ADAPT_THRESH_EN
        // One spike at threshold 100 raises the effective threshold to 112
        do_reset();
        step_a(1, 0, 0, 100);
        step_a(1, 1, 100, 100);
        for (int i = 0; i < 5; i++) step_a(1, 0, 0, 100);
        step_a(1, 1, 111, 100);
        chk("adapt_below", 0, a_spike, a_sv, a_refrac, 1'b0, 20'd111, 1'b0);
        step_a(1, 1, 1, 100);
        chk("adapt_cross", 0, a_spike, a_sv, a_refrac, 1'b1, 20'd112, 1'b0);
`endif

        // Leak: v=160 decays to 150 then 141; leak precedes the add on cycle 48
        do_reset();
        step_b(1, 0, 0, 100000);
        step_b(1, 1, 127, 100000);
        step_b(1, 1, 33, 100000);
        chk("leak_k", 2, b_spike, b_sv, b_refrac, 1'b0, 20'd160, 1'b0);
        for (int k = 3; k <= 48; k++) begin
            if (k == 48) step_b(1, 1, 5, 100000);
            else         step_b(1, 0, 0, 100000);
            if (k == 15) chk("leak_k", k, b_spike, b_sv, b_refrac, 1'b0, 20'd160, 1'b0);
            if (k == 16) chk("leak_k", k, b_spike, b_sv, b_refrac, 1'b0, 20'd150, 1'b0);
            if (k == 31) chk("leak_k", k, b_spike, b_sv, b_refrac, 1'b0, 20'd150, 1'b0);
            if (k == 32) chk("leak_k", k, b_spike, b_sv, b_refrac, 1'b0, 20'd141, 1'b0);
            if (k == 48) chk("leak_k", k, b_spike, b_sv, b_refrac, 1'b0, 20'd138, 1'b0);
        end

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        thr_r = 300;
        for (int c = 0; c < 3000; c++) begin
            bit en_r, vld_r;
            int wt_r;
            if (c % 64 == 0) thr_r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1500));
            en_r  = ($urandom_range(0, 19) != 0);
            vld_r = ($urandom_range(0, 9) < 7);
            wt_r  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 127))
                                               : -int'($urandom_range(1, 128));
            step_b(en_r, vld_r, wt_r, thr_r);
            model_cycle(en_r, vld_r, wt_r, thr_r);
            esv20 = e_sv[19:0];
            chk("rand", c, b_spike, b_sv, b_refrac, e_sp, esv20, e_rf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
